// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bus of the two-requester ALU arbiter.
// The master side is the surrounding core (requesters, ALU, response consumer).
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             flush;

  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [5:0]       req0_opcode;
  logic [5:0]       req0_funct;
  logic [4:0]       req0_shamt;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [5:0]       req1_opcode;
  logic [5:0]       req1_funct;
  logic [4:0]       req1_shamt;
  logic [TAG_W-1:0] req1_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [5:0]       alu_opcode;
  logic [5:0]       alu_funct;
  logic [4:0]       alu_shamt;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_carry;
  logic             rsp_illegal;

  modport slave (
    input  flush,
    input  req0_valid, req0_a, req0_b, req0_opcode, req0_funct, req0_shamt, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_opcode, req1_funct, req1_shamt, req1_tag,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode, alu_funct, alu_shamt,
    input  alu_result, alu_zero, alu_overflow, alu_carry,
    output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output flush,
    output req0_valid, req0_a, req0_b, req0_opcode, req0_funct, req0_shamt, req0_tag,
    output req1_valid, req1_a, req1_b, req1_opcode, req1_funct, req1_shamt, req1_tag,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode, alu_funct, alu_shamt,
    output alu_result, alu_zero, alu_overflow, alu_carry,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with an issue register driving the ALU and a backpressured response register.
module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  logic             r_i_valid;
  logic [31:0]      r_i_a;
  logic [31:0]      r_i_b;
  logic [5:0]       r_i_opcode;
  logic [5:0]       r_i_funct;
  logic [4:0]       r_i_shamt;
  logic             r_i_id;
  logic [TAG_W-1:0] r_i_tag;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_overflow;
  logic             r_rsp_carry;
  logic             r_rsp_illegal;

  logic             r_last_grant;

  logic w_r_adv;
  logic w_i_adv;
  logic w_can_accept;
  logic w_grant;
  logic w_accept;
  logic w_illegal;

  assign w_r_adv      = !r_rsp_valid || bus.rsp_ready;
  assign w_i_adv      = !r_i_valid || w_r_adv;
  // Gating with rst_n keeps both readies low while reset is held.
  assign w_can_accept = rst_n && w_i_adv && !bus.flush;
  assign w_grant      = (bus.req0_valid && bus.req1_valid) ? !r_last_grant : bus.req1_valid;
  assign w_accept     = w_can_accept && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = w_accept && !w_grant;
  assign bus.req1_ready = w_accept &&  w_grant;

  always_comb begin
    // NOTE: default assigned first so every path writes w_illegal and no latch is inferred.
    w_illegal = 1'b1;
    if (r_i_opcode == 6'b000000) begin
      case (r_i_funct)
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b000000, 6'b000001, 6'b011000,
        6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b000010, 6'b000011, 6'b101010:
          w_illegal = 1'b0;
        default: ;
      endcase
    end else begin
      case (r_i_opcode)
        6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011:
          w_illegal = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so the ALU bus reads zero until the first accept.
      r_i_valid    <= 1'b0;
      r_i_a        <= '0;
      r_i_b        <= '0;
      r_i_opcode   <= '0;
      r_i_funct    <= '0;
      r_i_shamt    <= '0;
      r_i_id       <= 1'b0;
      r_i_tag      <= '0;
      r_last_grant <= 1'b1;
    end else if (bus.flush) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_i_valid <= 1'b0;
    end else if (w_accept) begin
      r_i_valid    <= 1'b1;
      r_i_a        <= w_grant ? bus.req1_a      : bus.req0_a;
      r_i_b        <= w_grant ? bus.req1_b      : bus.req0_b;
      r_i_opcode   <= w_grant ? bus.req1_opcode : bus.req0_opcode;
      r_i_funct    <= w_grant ? bus.req1_funct  : bus.req0_funct;
      r_i_shamt    <= w_grant ? bus.req1_shamt  : bus.req0_shamt;
      r_i_tag      <= w_grant ? bus.req1_tag    : bus.req0_tag;
      r_i_id       <= w_grant;
      r_last_grant <= w_grant;
    end else if (w_r_adv) begin
      r_i_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_tag      <= '0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_illegal  <= 1'b0;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_r_adv) begin
      r_rsp_valid <= r_i_valid;
      if (r_i_valid) begin
        r_rsp_id       <= r_i_id;
        r_rsp_tag      <= r_i_tag;
        r_rsp_result   <= bus.alu_result;
        r_rsp_zero     <= bus.alu_zero;
        r_rsp_overflow <= bus.alu_overflow;
        r_rsp_carry    <= bus.alu_carry;
        r_rsp_illegal  <= w_illegal;
      end
    end
  end

  assign bus.alu_a      = r_i_a;
  assign bus.alu_b      = r_i_b;
  assign bus.alu_opcode = r_i_opcode;
  assign bus.alu_funct  = r_i_funct;
  assign bus.alu_shamt  = r_i_shamt;

  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_tag      = r_rsp_tag;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_carry    = r_rsp_carry;
  assign bus.rsp_illegal  = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU behind the DUT, and a queue-based
// model of in-flight ops that predicts readies and responses every cycle.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        carry;
  } alu_out_t;

  localparam logic [5:0] R_FUNCTS [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
    6'b000000, 6'b000001, 6'b011000, 6'b100100, 6'b100101, 6'b100111, 6'b100110,
    6'b000010, 6'b000011, 6'b101010};
  localparam logic [5:0] I_OPS [7] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101,
    6'b001110, 6'b001010, 6'b001011};

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  alu_arbiter_if #(.TAG_W(4)) bus ();
  alu_arbiter #(.TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic alu_out_t alu_fn(logic [31:0] a, logic [31:0] b, logic [5:0] op,
                                      logic [5:0] fn, logic [4:0] sh);
    alu_out_t r;
    logic [32:0] s;
    r = '0;
    s = '0;
    if (op == 6'b000000) begin
      case (fn)
        6'b100000, 6'b100001: begin
          s = {1'b0, a} + {1'b0, b};
          r.result = s[31:0];
          r.carry = s[32];
          r.ovf = (fn == 6'b100000) && (a[31] == b[31]) && (s[31] != a[31]);
        end
        6'b100010, 6'b100011: begin
          s = {1'b0, a} - {1'b0, b};
          r.result = s[31:0];
          r.carry = s[32];
          r.ovf = (fn == 6'b100010) && (a[31] != b[31]) && (s[31] != a[31]);
        end
        6'b000000: r.result = b << sh;
        6'b000001: r.result = b << a[4:0];
        6'b011000: r.result = a * b;
        6'b100100: r.result = a & b;
        6'b100101: r.result = a | b;
        6'b100111: r.result = ~(a | b);
        6'b100110: r.result = a ^ b;
        6'b000010: r.result = b >> sh;
        6'b000011: r.result = 32'($signed(b) >>> sh);
        6'b101010: r.result = {31'b0, $signed(a) < $signed(b)};
        default: ;
      endcase
    end else begin
      case (op)
        6'b001000, 6'b001001: begin
          s = {1'b0, a} + {1'b0, b};
          r.result = s[31:0];
          r.carry = s[32];
          r.ovf = (op == 6'b001000) && (a[31] == b[31]) && (s[31] != a[31]);
        end
        6'b001100: r.result = a & b;
        6'b001101: r.result = a | b;
        6'b001110: r.result = a ^ b;
        6'b001010: r.result = {31'b0, $signed(a) < $signed(b)};
        6'b001011: r.result = {31'b0, a < b};
        default: ;
      endcase
    end
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  alu_out_t alu_o;
  assign alu_o = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_funct, bus.alu_shamt);
  assign bus.alu_result   = alu_o.result;
  assign bus.alu_zero     = alu_o.zero;
  assign bus.alu_overflow = alu_o.ovf;
  assign bus.alu_carry    = alu_o.carry;

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b000000) begin
      foreach (R_FUNCTS[i]) if (R_FUNCTS[i] == fn) return 1'b1;
    end else begin
      foreach (I_OPS[i]) if (I_OPS[i] == op) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic op_t mk_op(logic [31:0] a, logic [31:0] b, logic [5:0] op,
                                logic [5:0] fn, logic [4:0] sh, logic [3:0] tag);
    op_t o;
    o = '{id: 1'b0, tag: tag, a: a, b: b, opcode: op, funct: fn, shamt: sh};
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  sel;
    sel = $urandom_range(0, 19);
    o = mk_op($urandom, $urandom, 6'd0, 6'd0, 5'($urandom), 4'($urandom));
    if (sel < 13) o.funct = R_FUNCTS[$urandom_range(0, 13)];
    else if (sel < 18) begin
      o.opcode = I_OPS[$urandom_range(0, 6)];
      o.funct = 6'($urandom);
    end else begin
      o.opcode = 6'($urandom);
      o.funct = 6'($urandom);
    end
    if ($urandom_range(0, 7) == 0) o.b = o.a;
    return o;
  endfunction

  // Reference model: q holds in-flight ops oldest first; m_present means q[0] sits in the response slot.
  op_t         q[$];
  bit          m_present;
  bit          m_last;
  bit          m_acc;
  bit          m_acc_id;
  bit          e_rdy0, e_rdy1, e_rv;
  logic [40:0] e_pay;

  op_t drv [2];
  bit  v [2];
  bit  rspr;
  bit  fl;

  function automatic logic [40:0] exp_pay(op_t o);
    alu_out_t r;
    r = alu_fn(o.a, o.b, o.opcode, o.funct, o.shamt);
    return {o.id, o.tag, r.result, r.zero, r.ovf, r.carry, !is_legal(o.opcode, o.funct)};
  endfunction

  function automatic logic [40:0] obs_pay();
    return {bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_overflow,
            bus.rsp_carry, bus.rsp_illegal};
  endfunction

  task automatic model_reset();
    q.delete();
    m_present = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic model_eval();
    int icnt;
    bit can;
    bit win;
    icnt = q.size() - int'(m_present);
    can = rst_n && (icnt == 0 || !m_present || rspr) && !fl;
    win = (v[0] && v[1]) ? !m_last : v[1];
    m_acc = can && (v[0] || v[1]);
    m_acc_id = win;
    e_rdy0 = m_acc && !win;
    e_rdy1 = m_acc && win;
    e_rv = m_present;
    e_pay = m_present ? exp_pay(q[0]) : '0;
  endtask

  task automatic model_step();
    int  icnt;
    op_t o;
    icnt = q.size() - int'(m_present);
    if (fl) begin
      q.delete();
      m_present = 1'b0;
      return;
    end
    if (!m_present || rspr) begin
      if (m_present) void'(q.pop_front());
      m_present = (icnt == 1);
    end
    if (m_acc) begin
      o = drv[m_acc_id];
      o.id = m_acc_id;
      q.push_back(o);
      m_last = m_acc_id;
    end
  endtask

  task automatic apply();
    bus.flush       = fl;
    bus.rsp_ready   = rspr;
    bus.req0_valid  = v[0];
    bus.req0_a      = drv[0].a;
    bus.req0_b      = drv[0].b;
    bus.req0_opcode = drv[0].opcode;
    bus.req0_funct  = drv[0].funct;
    bus.req0_shamt  = drv[0].shamt;
    bus.req0_tag    = drv[0].tag;
    bus.req1_valid  = v[1];
    bus.req1_a      = drv[1].a;
    bus.req1_b      = drv[1].b;
    bus.req1_opcode = drv[1].opcode;
    bus.req1_funct  = drv[1].funct;
    bus.req1_shamt  = drv[1].shamt;
    bus.req1_tag    = drv[1].tag;
  endtask

  task automatic settle();
    apply();
    #1;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    @(negedge clk);
    settle();
  endtask

  task automatic drain();
    v = '{1'b0, 1'b0};
    fl = 1'b0;
    rspr = 1'b1;
    settle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv[0] = mk_op(32'd9, 32'd4, 6'd0, 6'b100000, 5'd0, 4'd1);
    drv[1] = rand_op();
    v = '{1'b1, 1'b1};
    rspr = 1'b1;
    fl = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
    end
    total++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_funct} !== 76'd0) begin
      bad++;
      $display("FAIL reset_alu_bus: got a=%h b=%h want 0", bus.alu_a, bus.alu_b);
    end
    total++;
    if (obs_pay() !== 41'd0) begin
      bad++;
      $display("FAIL reset_rsp: got %h want 0", obs_pay());
    end
    v = '{1'b0, 1'b0};
    apply();
    #1 rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_basic();
    drv[0] = mk_op(32'd5, 32'd7, 6'b000000, 6'b100000, 5'd0, 4'd3);
    v = '{1'b1, 1'b0};
    rspr = 1'b1;
    settle();
    model_eval();
    total++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {e_rdy0, e_rdy1, e_rv} || !e_rdy0) begin
      bad++;
      $display("FAIL basic_ready: got %b want 100", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
    end
    tick();
    v = '{1'b0, 1'b0};
    settle();
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
    end
    tick();
    total++;
    if ({bus.rsp_valid, obs_pay()} !== {1'b1, 1'b0, 4'd3, 32'd12, 4'b0000}) begin
      bad++;
      $display("FAIL basic_rsp: got v=%b %h want v=1 %h", bus.rsp_valid, obs_pay(),
               {1'b0, 4'd3, 32'd12, 4'b0000});
    end
    drain();
  endtask

  task automatic test_round_robin();
    int nrsp;
    nrsp = 0;
    drv[0] = rand_op();
    drv[1] = rand_op();
    v = '{1'b1, 1'b1};
    rspr = 1'b1;
    settle();
    for (int i = 0; i < 20; i++) begin
      model_eval();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {e_rdy0, e_rdy1, e_rv}) begin
        bad++;
        $display("FAIL rr_ctrl: got %b want %b", {bus.req0_ready, bus.req1_ready, bus.rsp_valid},
                 {e_rdy0, e_rdy1, e_rv});
      end
      if (e_rv) begin
        total++;
        if (obs_pay() !== e_pay) begin
          bad++;
          $display("FAIL rr_payload: got %h want %h", obs_pay(), e_pay);
        end
      end
      if (bus.rsp_valid === 1'b1) nrsp++;
      tick();
      if (m_acc) drv[m_acc_id] = rand_op();
      settle();
    end
    total++;
    if (nrsp != 18) begin
      bad++;
      $display("FAIL rr_throughput: got %0d responses want 18", nrsp);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int nacc;
    op_t io;
    nacc = 0;
    drv[0] = rand_op();
    v = '{1'b1, 1'b0};
    rspr = 1'b0;
    settle();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        rspr = 1'b1;
        settle();
        total++;
        if (bus.req0_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_ready_return: got %b want 1", bus.req0_ready);
        end
      end
      model_eval();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {e_rdy0, e_rdy1, e_rv}) begin
        bad++;
        $display("FAIL bp_ctrl: got %b want %b", {bus.req0_ready, bus.req1_ready, bus.rsp_valid},
                 {e_rdy0, e_rdy1, e_rv});
      end
      if (e_rv) begin
        total++;
        if (obs_pay() !== e_pay) begin
          bad++;
          $display("FAIL bp_payload: got %h want %h", obs_pay(), e_pay);
        end
      end
      if (q.size() > int'(m_present)) begin
        io = q[m_present ? 1 : 0];
        total++;
        if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_funct} !== {io.a, io.b, io.opcode, io.funct}) begin
          bad++;
          $display("FAIL bp_alu_bus: got a=%h b=%h want a=%h b=%h", bus.alu_a, bus.alu_b, io.a, io.b);
        end
      end
      if (i < 5 && bus.req0_ready === 1'b1) nacc++;
      if (i == 5) begin
        total++;
        if (nacc != 2) begin
          bad++;
          $display("FAIL bp_accepts: got %0d want 2", nacc);
        end
      end
      tick();
      if (m_acc) drv[m_acc_id] = rand_op();
      settle();
    end
    drain();
  endtask

  task automatic test_directed();
    op_t         ops [3];
    bit          ids [3];
    logic [31:0] exp_res [3];
    logic [1:0]  exp_fl [3];
    ops[0] = mk_op($urandom, $urandom, 6'b000000, 6'b111111, 5'd0, 4'd6);
    ops[1] = mk_op(32'hFFFF_FFFF, 32'd0, 6'b001010, 6'd0, 5'd0, 4'd7);
    ops[2] = mk_op(32'h7FFF_FFFF, 32'd1, 6'b000000, 6'b100000, 5'd0, 4'd8);
    ids = '{1'b1, 1'b0, 1'b1};
    exp_res = '{32'd0, 32'd1, 32'h8000_0000};
    exp_fl = '{2'b01, 2'b00, 2'b10};  // {overflow, illegal}
    for (int k = 0; k < 3; k++) begin
      drv[ids[k]] = ops[k];
      v = '{1'b0, 1'b0};
      v[ids[k]] = 1'b1;
      settle();
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== {!ids[k], ids[k]}) begin
        bad++;
        $display("FAIL dir_ready[%0d]: got %b want %b", k, {bus.req0_ready, bus.req1_ready},
                 {!ids[k], ids[k]});
      end
      tick();
      v = '{1'b0, 1'b0};
      settle();
      tick();
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_overflow, bus.rsp_illegal}
          !== {1'b1, ids[k], ops[k].tag, exp_res[k], exp_fl[k]}) begin
        bad++;
        $display("FAIL dir_rsp[%0d]: got v=%b id=%b tag=%h res=%h ovf=%b ill=%b want id=%b tag=%h res=%h ovf/ill=%b",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_overflow,
                 bus.rsp_illegal, ids[k], ops[k].tag, exp_res[k], exp_fl[k]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      v[0] = ($urandom_range(0, 9) < 6);
      v[1] = ($urandom_range(0, 9) < 6);
      rspr = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 24) == 0);
      settle();
      model_eval();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {e_rdy0, e_rdy1, e_rv}) begin
        bad++;
        $display("FAIL rand_ctrl @%0d: got %b want %b", i, {bus.req0_ready, bus.req1_ready, bus.rsp_valid},
                 {e_rdy0, e_rdy1, e_rv});
      end
      if (e_rv) begin
        total++;
        if (obs_pay() !== e_pay) begin
          bad++;
          $display("FAIL rand_payload @%0d: got %h want %h", i, obs_pay(), e_pay);
        end
      end
      tick();
      if (m_acc) drv[m_acc_id] = rand_op();
    end
    drain();
  endtask

  // use_reset selects an asynchronous reset pulse instead of a flush pulse.
  task automatic test_clear(bit use_reset);
    drv[0] = rand_op();
    v = '{1'b1, 1'b0};
    rspr = 1'b0;
    settle();
    tick();
    drv[0] = rand_op();
    settle();
    tick();
    v = '{1'b0, 1'b0};
    if (use_reset) begin
      rst_n = 1'b0;
      settle();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000) begin
        bad++;
        $display("FAIL rst_mid: got %b want 000", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
      end
      model_reset();
      rst_n = 1'b1;
      #1;
    end else begin
      fl = 1'b1;
      v = '{1'b1, 1'b1};
      settle();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b001) begin
        bad++;
        $display("FAIL flush_ready: got %b want 001", {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
      end
      tick();
      fl = 1'b0;
      v = '{1'b0, 1'b0};
      settle();
    end
    rspr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        drv[1] = rand_op();
        v = '{1'b0, 1'b1};
      end
      if (i == 4) v = '{1'b0, 1'b0};
      settle();
      model_eval();
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {e_rdy0, e_rdy1, e_rv}) begin
        bad++;
        $display("FAIL clear_ctrl[%0d] @%0d: got %b want %b", use_reset, i,
                 {bus.req0_ready, bus.req1_ready, bus.rsp_valid}, {e_rdy0, e_rdy1, e_rv});
      end
      if (e_rv) begin
        total++;
        if (obs_pay() !== e_pay) begin
          bad++;
          $display("FAIL clear_payload[%0d]: got %h want %h", use_reset, obs_pay(), e_pay);
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_directed();
    test_random();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and two-stage issue pipeline that shares the single combinational `alu` instance between the integer execute pipeline (requester 0) and the address/auxiliary unit (requester 1). It does four things:
- accepts operations over valid/ready handshakes;
- picks a winner round-robin;
- registers the operands onto the ALU input bus;
- captures the ALU result and flags into a response register with backpressure.

It also flags opcode/funct combinations the ALU does not implement.

## Interface
- `TAG_W`, 4: width of the requester-supplied tag carried to the response.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous pipeline clear
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `reqN_a`, `reqN_b`  in  32  operands
- `reqN_opcode`  in  6  instruction opcode
- `reqN_funct`  in  6  R-type function code
- `reqN_shamt`  in  5  shift amount
- `reqN_tag`  in  `TAG_W`  opaque tag
- `alu_a`, `alu_b`  out  32  operands driven to the ALU
- `alu_opcode`, `alu_funct`  out  6  driven to the ALU
- `alu_shamt`  out  5  driven to the ALU
- `alu_result`  in  32  ALU result
- `alu_zero`, `alu_overflow`, `alu_carry`  in  1  ALU flags
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the op
- `rsp_tag`  out  `TAG_W`  tag of the op
- `rsp_result`  out  32  captured result
- `rsp_zero`, `rsp_overflow`, `rsp_carry`  out  1  captured flags
- `rsp_illegal`  out  1  op not supported by the ALU

## Operation
- **Pipeline stages.**
  - Stage I (issue register): valid bit plus operands, opcode, funct, shamt, id, tag. It drives the `alu_*` outputs directly.
  - Stage R (response register): valid bit plus result, flags, id, tag, illegal.
- **Advance conditions.**
  - `r_adv` = `!rsp_valid | rsp_ready`.
  - `i_adv` = `!i_valid | r_adv`.
  - A request can be accepted only when `i_adv` is true and `flush` is low.
- **Arbitration.**
  - Register `last_grant` holds the last requester granted.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester ≠ `last_grant` wins.
  - `last_grant` updates only on an actual acceptance.
- **Ready.** `reqN_ready` is high only for the winner while accept is possible. It is combinational from `reqN_valid`, the Stage I/R valid bits, `rsp_ready` and `flush`. Ready is never high for both requesters in the same cycle.
- **Transfer.** A transfer happens when `valid & ready` are both high; Stage I loads on that edge.
- **Stage I → R.**
  - On `r_adv` with `i_valid`, Stage R captures the ALU outputs and Stage I's id and tag.
  - If Stage I empties without a new accept, `i_valid` clears.
- **Hold.** When `!r_adv`, both stages hold and all Stage I outputs stay stable.
- **Legality.** `rsp_illegal` = 1 unless one of the following holds:
  - opcode 000000 with funct in {100000, 100001, 100010, 100011, 000000, 000001, 011000, 100100, 100101, 100111, 100110, 000010, 000011, 101010};
  - opcode in {001000, 001001, 001100, 001101, 001110, 001010, 001011}.
- **Illegal ops** still flow through the pipeline. The result is whatever the ALU drives (0), and the flags are passed through unchanged.
- **Flush.**
  - `i_valid` and `rsp_valid` clear at the next edge, regardless of `rsp_ready`.
  - No request is accepted in a flush cycle; both readies are low.
  - `last_grant` is unchanged.
- **Reset.** Asynchronous on `rst_n` low:
  - `i_valid` = 0 and `rsp_valid` = 0;
  - `last_grant` = 1, so requester 0 wins the first tie;
  - all data registers are 0.

## Timing
- **Reset values.** All outputs are 0 during and after reset until the first accept. This covers `reqN_ready`, which is low while `rst_n` is low.
- **Latency.** Accept at edge k → Stage I valid after k. `rsp_valid` = 1 after edge k+1. Total: 2 cycles from accept to response.
- **Throughput.** One op per cycle while `rsp_ready` = 1. Two back-to-back requesters alternate every cycle.
- **Backpressure.**
  - With `rsp_valid` = 1 and `rsp_ready` = 0, Stage I may still accept one op if empty. The pipeline then holds 2 ops and ready drops.
  - Ready returns in the same cycle that `rsp_ready` rises.
- **Simultaneous events.** A response being consumed and a new accept at the same edge are both taken. `flush` overrides all accepts and captures at the same edge.
- **Reset mid-operation.** Any in-flight op is discarded and no response is produced for it.

## Test plan
- Reset release; hold `req0` with a=5, b=7, opcode 000000, funct 100000, tag 3 → `req0_ready` = 1 in the first cycle; `rsp_valid` two cycles after accept with result 12, `rsp_id` 0, tag 3, zero 0, illegal 0.
- Both requesters continuously valid, `rsp_ready` = 1 → grants go 0, 1, 0, 1…; `rsp_id` alternates with one response per cycle and no lost or duplicated tags.
- `rsp_ready` held 0 for 5 cycles with `req0` valid → exactly 2 accepts, then ready stays low and `rsp_*` holds stable. On release, the responses drain in order and ready reasserts in the same cycle.
- `req1` with opcode 000000, funct 111111 → `rsp_illegal` = 1, result 0. Opcode 001010 with a = −1, b = 0 → result 1, illegal 0.
- Overflow case: opcode 000000, funct 100000, a = 0x7FFFFFFF, b = 1 → result 0x80000000 with overflow captured from the ALU.
- Two ops in flight, `flush` pulsed for 1 cycle (then async `rst_n` pulse in a second run) → `rsp_valid` = 0 next cycle, no response for either op, and the next accept works normally.
